// File: rtl/p4_if_pkg.sv
// Shared types and defaults for the P4 output merger: FSM states, grant index
// type and the default AXI-Stream widths.
package p4_if_pkg;

  localparam int NUM_VSW         = 4;
  localparam int DEF_DATA_WIDTH  = 256;
  localparam int DEF_TUSER_WIDTH = 128;
  localparam int DEF_CNT_WIDTH   = 32;

  typedef logic [1:0] grant_t;

  // Input 3 as the reset "last served" index gives input 0 first priority.
  localparam grant_t GRANT_RESET = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

endpackage

// File: rtl/p4_rr_arbiter.sv
// Combinational 4-way round-robin pick: the first requesting input after
// last_grant (last_grant+1 .. last_grant+4, mod 4) wins.
module p4_rr_arbiter
  import p4_if_pkg::*;
(
  input  logic [NUM_VSW-1:0] req,
  input  grant_t             last_grant,
  output grant_t             grant,
  output logic               any_req
);

  grant_t probe;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and no latch is inferred.
    grant   = '0;
    probe   = '0;
    any_req = |req;
    // Walk from the farthest offset down so the nearest requester is written last.
    for (int i = NUM_VSW; i >= 1; i--) begin
      probe = last_grant + grant_t'(i);
      if (req[probe]) grant = probe;
    end
  end

endmodule

// File: rtl/output_p4_interface.sv
// Merges four per-vSwitch AXI-Stream outputs into one stream, arbitrating
// per packet with round-robin fairness, through a single output register.
module output_p4_interface
  import p4_if_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int C_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int CNT_WIDTH          = DEF_CNT_WIDTH
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_0_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_0_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_0_tuser,
  input  logic                            s_axis_0_tvalid,
  input  logic                            s_axis_0_tlast,
  output logic                            s_axis_0_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_1_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_1_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_1_tuser,
  input  logic                            s_axis_1_tvalid,
  input  logic                            s_axis_1_tlast,
  output logic                            s_axis_1_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_2_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_2_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_2_tuser,
  input  logic                            s_axis_2_tvalid,
  input  logic                            s_axis_2_tlast,
  output logic                            s_axis_2_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_3_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_3_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_3_tuser,
  input  logic                            s_axis_3_tvalid,
  input  logic                            s_axis_3_tlast,
  output logic                            s_axis_3_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,

  output logic [CNT_WIDTH-1:0]            pkt_cnt_0,
  output logic [CNT_WIDTH-1:0]            pkt_cnt_1,
  output logic [CNT_WIDTH-1:0]            pkt_cnt_2,
  output logic [CNT_WIDTH-1:0]            pkt_cnt_3,
  output logic [1:0]                      cur_grant,
  output logic                            busy
);

  localparam int KEEP_WIDTH = C_AXIS_DATA_WIDTH / 8;

  logic [C_AXIS_DATA_WIDTH-1:0]  in_data [NUM_VSW];
  logic [KEEP_WIDTH-1:0]         in_keep [NUM_VSW];
  logic [C_AXIS_TUSER_WIDTH-1:0] in_user [NUM_VSW];
  logic [NUM_VSW-1:0]            in_valid;
  logic [NUM_VSW-1:0]            in_last;
  logic [NUM_VSW-1:0]            in_ready;

  assign in_data  = '{s_axis_0_tdata, s_axis_1_tdata, s_axis_2_tdata, s_axis_3_tdata};
  assign in_keep  = '{s_axis_0_tkeep, s_axis_1_tkeep, s_axis_2_tkeep, s_axis_3_tkeep};
  assign in_user  = '{s_axis_0_tuser, s_axis_1_tuser, s_axis_2_tuser, s_axis_3_tuser};
  assign in_valid = {s_axis_3_tvalid, s_axis_2_tvalid, s_axis_1_tvalid, s_axis_0_tvalid};
  assign in_last  = {s_axis_3_tlast, s_axis_2_tlast, s_axis_1_tlast, s_axis_0_tlast};

  state_t state, state_next;
  grant_t grant_q, grant_next, last_grant_q, arb_grant;
  logic   any_req;
  logic   out_ready, accept, accept_last;
  logic [CNT_WIDTH-1:0] pkt_cnt [NUM_VSW];

  p4_rr_arbiter u_arb (
    .req        (in_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .any_req    (any_req)
  );

  // The output register can take a new beat when empty or being drained.
  assign out_ready   = !m_axis_tvalid || m_axis_tready;
  assign accept      = (state == PKT) && out_ready && in_valid[grant_q];
  assign accept_last = accept && in_last[grant_q];

  always_comb begin
    in_ready = '0;
    if (state == PKT && out_ready) in_ready[grant_q] = 1'b1;
  end

  assign s_axis_0_tready = in_ready[0];
  assign s_axis_1_tready = in_ready[1];
  assign s_axis_2_tready = in_ready[2];
  assign s_axis_3_tready = in_ready[3];

  always_comb begin
    state_next = state;
    grant_next = grant_q;
    case (state)
      IDLE: if (any_req) begin
        state_next = PKT;
        grant_next = arb_grant;
      end
      PKT:  if (accept_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values regardless of statement order.
    if (axis_reset) begin
      state        <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_RESET;
    end else begin
      state   <= state_next;
      grant_q <= grant_next;
      if (accept_last) last_grant_q <= grant_q;
    end
  end

  always_ff @(posedge axis_aclk) begin
    // NOTE: the datapath register is reset as well because the stream must present all-zero outputs out of reset; a plain pipeline stage would not need it.
    if (axis_reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
    end else if (out_ready) begin
      m_axis_tvalid <= accept;
      if (accept) begin
        m_axis_tlast <= in_last[grant_q];
        m_axis_tdata <= in_data[grant_q];
        m_axis_tkeep <= in_keep[grant_q];
        m_axis_tuser <= in_user[grant_q];
      end
    end
  end

  // Counters wrap naturally at 2^CNT_WIDTH.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      for (int i = 0; i < NUM_VSW; i++) pkt_cnt[i] <= '0;
    end else if (accept_last) begin
      pkt_cnt[grant_q] <= pkt_cnt[grant_q] + CNT_WIDTH'(1);
    end
  end

  assign pkt_cnt_0 = pkt_cnt[0];
  assign pkt_cnt_1 = pkt_cnt[1];
  assign pkt_cnt_2 = pkt_cnt[2];
  assign pkt_cnt_3 = pkt_cnt[3];
  assign cur_grant = grant_q;
  assign busy      = (state == PKT);

endmodule

// File: tb/tb_output_p4_interface.sv
// Directed bench for output_p4_interface: per-input packet sources, an output
// monitor and one task per scenario with hand-computed expectations.
module tb_output_p4_interface;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = DW / 8;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata [4];
  logic [KW-1:0] s_tkeep [4];
  logic [UW-1:0] s_tuser [4];
  logic [3:0]    s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b1;
  logic [CW-1:0] cnt [4];
  logic [1:0]    cur_grant;
  logic          busy;

  output_p4_interface dut (
    .axis_aclk(clk), .axis_reset(rst),
    .s_axis_0_tdata(s_tdata[0]), .s_axis_0_tkeep(s_tkeep[0]), .s_axis_0_tuser(s_tuser[0]),
    .s_axis_0_tvalid(s_tvalid[0]), .s_axis_0_tlast(s_tlast[0]), .s_axis_0_tready(s_tready[0]),
    .s_axis_1_tdata(s_tdata[1]), .s_axis_1_tkeep(s_tkeep[1]), .s_axis_1_tuser(s_tuser[1]),
    .s_axis_1_tvalid(s_tvalid[1]), .s_axis_1_tlast(s_tlast[1]), .s_axis_1_tready(s_tready[1]),
    .s_axis_2_tdata(s_tdata[2]), .s_axis_2_tkeep(s_tkeep[2]), .s_axis_2_tuser(s_tuser[2]),
    .s_axis_2_tvalid(s_tvalid[2]), .s_axis_2_tlast(s_tlast[2]), .s_axis_2_tready(s_tready[2]),
    .s_axis_3_tdata(s_tdata[3]), .s_axis_3_tkeep(s_tkeep[3]), .s_axis_3_tuser(s_tuser[3]),
    .s_axis_3_tvalid(s_tvalid[3]), .s_axis_3_tlast(s_tlast[3]), .s_axis_3_tready(s_tready[3]),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .pkt_cnt_0(cnt[0]), .pkt_cnt_1(cnt[1]), .pkt_cnt_2(cnt[2]), .pkt_cnt_3(cnt[3]),
    .cur_grant(cur_grant), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Deterministic sideband derived from source index and data byte.
  function automatic logic [UW-1:0] user_of(int src, logic [7:0] d);
    return {96'h0, 8'(src), 16'hC0DE, d};
  endfunction

  function automatic logic [KW-1:0] keep_of(logic last);
    return last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  // Source programming (written only by the stimulus tasks).
  logic [7:0] src_d [4][16];
  logic       src_l [4][16];
  int         src_len [4];
  logic       src_en [4];
  int         hold_at [4];
  int         hold_len [4];
  int         src_gen = 0;
  int         mon_gen = 0;
  logic       bp_en = 1'b0;
  logic [7:0] bp_pat = 8'b0110_1001;  // LSB first: 1,0,0,1,0,1,1,0

  // Driver-owned state.
  int   cyc = 0;
  int   drv_gen = -1;
  int   src_idx [4];
  int   hold_cnt [4];
  int   first_vcyc [4];
  logic holding [4];

  // Monitor-owned state.
  int   mon_seen = -1;
  logic fire [4];
  logic [DW-1:0] out_d [$];
  logic [KW+UW:0] out_side [$];
  int   first_ocyc = -1;
  int   stall_viol = 0;
  logic prev_stall = 1'b0;
  logic [DW+KW+UW+1:0] prev_out, cur_out;

  // Expectations.
  int         exp_s [$];
  logic [7:0] exp_d [$];
  logic       exp_l [$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (drv_gen != src_gen) begin
        src_idx[i] = 0; hold_cnt[i] = 0; first_vcyc[i] = -1;
      end else if (fire[i]) begin
        src_idx[i]++;
      end
      holding[i] = src_en[i] && (src_idx[i] == hold_at[i]) && (hold_cnt[i] < hold_len[i]);
      if (holding[i]) hold_cnt[i]++;
      if (src_en[i] && !holding[i] && src_idx[i] < src_len[i]) begin
        s_tvalid[i] = 1'b1;
        s_tdata[i]  = {248'h0, src_d[i][src_idx[i]]};
        s_tlast[i]  = src_l[i][src_idx[i]];
        s_tkeep[i]  = keep_of(src_l[i][src_idx[i]]);
        s_tuser[i]  = user_of(i, src_d[i][src_idx[i]]);
        if (first_vcyc[i] < 0) first_vcyc[i] = cyc;
      end else begin
        s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0;
        s_tdata[i] = '0; s_tkeep[i] = '0; s_tuser[i] = '0;
      end
    end
    drv_gen  = src_gen;
    m_tready = bp_en ? bp_pat[cyc % 8] : 1'b1;
  end

  always @(negedge clk) begin
    if (mon_seen != mon_gen) begin
      out_d.delete(); out_side.delete();
      first_ocyc = -1; stall_viol = 0; prev_stall = 1'b0;
      mon_seen = mon_gen;
    end
    for (int i = 0; i < 4; i++) fire[i] = s_tvalid[i] && s_tready[i];
    cur_out = {m_tvalid, m_tlast, m_tkeep, m_tuser, m_tdata};
    if (prev_stall && cur_out !== prev_out) stall_viol++;
    prev_stall = m_tvalid && !m_tready;
    prev_out   = cur_out;
    if (m_tvalid && m_tready) begin
      out_d.push_back(m_tdata);
      out_side.push_back({m_tkeep, m_tuser, m_tlast});
      if (first_ocyc < 0) first_ocyc = cyc;
    end
  end

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      src_en[i] = 1'b0; src_len[i] = 0; hold_at[i] = -1; hold_len[i] = 0;
    end
    exp_s.delete(); exp_d.delete(); exp_l.delete();
    bp_en = 1'b0;
    src_gen++;
    mon_gen++;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add_packet(int src, logic [7:0] base, int n);
    for (int b = 0; b < n; b++) begin
      src_d[src][src_len[src]] = base + 8'(b);
      src_l[src][src_len[src]] = (b == n - 1);
      src_len[src]++;
    end
  endtask

  task automatic expect_packet(int src, logic [7:0] base, int n);
    for (int b = 0; b < n; b++) begin
      exp_s.push_back(src);
      exp_d.push_back(base + 8'(b));
      exp_l.push_back(b == n - 1);
    end
  endtask

  task automatic wait_beats(int n);
    int budget = 300;
    while (out_d.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++; if ({m_tvalid, m_tlast} !== 2'b00) begin errors++; $display("FAIL reset_valid_last: got %b expected 00", {m_tvalid, m_tlast}); end
    checks++; if (m_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", m_tdata); end
    checks++; if ({m_tkeep, m_tuser} !== '0) begin errors++; $display("FAIL reset_keep_user: got %h expected 0", {m_tkeep, m_tuser}); end
    checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL reset_tready: got %b expected 0000", s_tready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cnt[i] !== '0) begin errors++; $display("FAIL reset_pkt_cnt_%0d: got %0d expected 0", i, cnt[i]); end
    end
    checks++; if (cur_grant !== 2'd0) begin errors++; $display("FAIL reset_cur_grant: got %0d expected 0", cur_grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_input();
    clear_all();
    do_reset(2);
    add_packet(2, 8'hA1, 3);
    expect_packet(2, 8'hA1, 3);
    src_en[2] = 1'b1;
    wait_beats(3);
    checks++; if (out_d.size() != 3) begin errors++; $display("FAIL single_beat_count: got %0d expected 3", out_d.size()); end
    for (int k = 0; k < exp_d.size() && k < out_d.size(); k++) begin
      checks++; if (out_d[k] !== {248'h0, exp_d[k]}) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", k, out_d[k][7:0], exp_d[k]); end
      checks++; if (out_side[k] !== {keep_of(exp_l[k]), user_of(exp_s[k], exp_d[k]), exp_l[k]}) begin errors++; $display("FAIL single_side[%0d]: got %h expected %h", k, out_side[k], {keep_of(exp_l[k]), user_of(exp_s[k], exp_d[k]), exp_l[k]}); end
    end
    checks++; if (first_ocyc - first_vcyc[2] != 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", first_ocyc - first_vcyc[2]); end
    checks++; if (cnt[2] !== 32'd1) begin errors++; $display("FAIL single_pkt_cnt_2: got %0d expected 1", cnt[2]); end
    checks++; if ({cnt[0], cnt[1], cnt[3]} !== '0) begin errors++; $display("FAIL single_other_cnts: got %0d/%0d/%0d expected 0/0/0", cnt[0], cnt[1], cnt[3]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    clear_all();
    do_reset(2);
    add_packet(0, 8'h01, 2);
    add_packet(0, 8'h05, 1);
    add_packet(1, 8'h11, 2);
    add_packet(2, 8'h21, 2);
    add_packet(3, 8'h31, 2);
    expect_packet(0, 8'h01, 2);
    expect_packet(1, 8'h11, 2);
    expect_packet(2, 8'h21, 2);
    expect_packet(3, 8'h31, 2);
    expect_packet(0, 8'h05, 1);
    for (int i = 0; i < 4; i++) src_en[i] = 1'b1;
    wait_beats(9);
    checks++; if (out_d.size() != 9) begin errors++; $display("FAIL rr_beat_count: got %0d expected 9", out_d.size()); end
    for (int k = 0; k < exp_d.size() && k < out_d.size(); k++) begin
      checks++; if (out_d[k] !== {248'h0, exp_d[k]}) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", k, out_d[k][7:0], exp_d[k]); end
      checks++; if (out_side[k] !== {keep_of(exp_l[k]), user_of(exp_s[k], exp_d[k]), exp_l[k]}) begin errors++; $display("FAIL rr_side[%0d]: got %h expected %h", k, out_side[k], {keep_of(exp_l[k]), user_of(exp_s[k], exp_d[k]), exp_l[k]}); end
    end
    checks++; if (cnt[0] !== 32'd2) begin errors++; $display("FAIL rr_pkt_cnt_0: got %0d expected 2", cnt[0]); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (cnt[i] !== 32'd1) begin errors++; $display("FAIL rr_pkt_cnt_%0d: got %0d expected 1", i, cnt[i]); end
    end
  endtask

  task automatic test_backpressure();
    clear_all();
    do_reset(2);
    mon_gen++;
    repeat (2) @(negedge clk);
    add_packet(1, 8'h41, 4);
    expect_packet(1, 8'h41, 4);
    bp_en = 1'b1;
    src_en[1] = 1'b1;
    wait_beats(4);
    bp_en = 1'b0;
    checks++; if (out_d.size() != 4) begin errors++; $display("FAIL bp_beat_count: got %0d expected 4", out_d.size()); end
    for (int k = 0; k < exp_d.size() && k < out_d.size(); k++) begin
      checks++; if (out_d[k] !== {248'h0, exp_d[k]}) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", k, out_d[k][7:0], exp_d[k]); end
      checks++; if (out_side[k] !== {keep_of(exp_l[k]), user_of(exp_s[k], exp_d[k]), exp_l[k]}) begin errors++; $display("FAIL bp_side[%0d]: got %h expected %h", k, out_side[k], {keep_of(exp_l[k]), user_of(exp_s[k], exp_d[k]), exp_l[k]}); end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable_while_stalled: got %0d changes expected 0", stall_viol); end
    checks++; if (cnt[1] !== 32'd1) begin errors++; $display("FAIL bp_pkt_cnt_1: got %0d expected 1", cnt[1]); end
  endtask

  task automatic test_grant_hold();
    int budget = 40;
    int hold_seen = 0;
    int bad = 0;
    clear_all();
    do_reset(2);
    add_packet(3, 8'h51, 4);
    add_packet(0, 8'h61, 2);
    expect_packet(3, 8'h51, 4);
    expect_packet(0, 8'h61, 2);
    hold_at[3] = 2;
    hold_len[3] = 5;
    src_en[3] = 1'b1;
    while (!(busy === 1'b1 && cur_grant === 2'd3) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++; if (!(busy === 1'b1 && cur_grant === 2'd3)) begin errors++; $display("FAIL hold_grant3_timeout: got busy=%b grant=%0d expected busy=1 grant=3", busy, cur_grant); end
    src_en[0] = 1'b1;
    budget = 300;
    while (out_d.size() < 6 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (holding[3]) begin
        hold_seen++;
        if (cur_grant !== 2'd3 || s_tready[0] !== 1'b0 || busy !== 1'b1) bad++;
      end
    end
    repeat (8) @(negedge clk);
    checks++; if (hold_seen != 5) begin errors++; $display("FAIL hold_cycles_seen: got %0d expected 5", hold_seen); end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_grant_kept: got %0d bad cycles expected 0", bad); end
    checks++; if (out_d.size() != 6) begin errors++; $display("FAIL hold_beat_count: got %0d expected 6", out_d.size()); end
    for (int k = 0; k < exp_d.size() && k < out_d.size(); k++) begin
      checks++; if (out_d[k] !== {248'h0, exp_d[k]}) begin errors++; $display("FAIL hold_data[%0d]: got %h expected %h", k, out_d[k][7:0], exp_d[k]); end
      checks++; if (out_side[k] !== {keep_of(exp_l[k]), user_of(exp_s[k], exp_d[k]), exp_l[k]}) begin errors++; $display("FAIL hold_side[%0d]: got %h expected %h", k, out_side[k], {keep_of(exp_l[k]), user_of(exp_s[k], exp_d[k]), exp_l[k]}); end
    end
    checks++; if ({cnt[0], cnt[3]} !== {32'd1, 32'd1}) begin errors++; $display("FAIL hold_pkt_cnts: got %0d/%0d expected 1/1", cnt[0], cnt[3]); end
  endtask

  task automatic test_reset_mid_packet();
    int budget = 40;
    clear_all();
    do_reset(2);
    add_packet(2, 8'h71, 4);
    src_en[2] = 1'b1;
    while (src_idx[2] < 1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++; if (src_idx[2] < 1) begin errors++; $display("FAIL midrst_beat2_timeout: got index %0d expected >=1", src_idx[2]); end
    rst = 1'b1;
    src_en[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if ({m_tvalid, busy, s_tready} !== 6'b0) begin errors++; $display("FAIL midrst_idle: got %b expected 000000", {m_tvalid, busy, s_tready}); end
    checks++; if ({cnt[0], cnt[1], cnt[2], cnt[3]} !== '0) begin errors++; $display("FAIL midrst_cnts: got %0d/%0d/%0d/%0d expected 0/0/0/0", cnt[0], cnt[1], cnt[2], cnt[3]); end
    clear_all();
    add_packet(1, 8'h81, 2);
    expect_packet(1, 8'h81, 2);
    src_en[1] = 1'b1;
    wait_beats(2);
    checks++; if (out_d.size() != 2) begin errors++; $display("FAIL midrst_beat_count: got %0d expected 2", out_d.size()); end
    for (int k = 0; k < exp_d.size() && k < out_d.size(); k++) begin
      checks++; if (out_d[k] !== {248'h0, exp_d[k]}) begin errors++; $display("FAIL midrst_data[%0d]: got %h expected %h", k, out_d[k][7:0], exp_d[k]); end
    end
    checks++; if ({cnt[1], cnt[2]} !== {32'd1, 32'd0}) begin errors++; $display("FAIL midrst_pkt_cnts: got %0d/%0d expected 1/0", cnt[1], cnt[2]); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      src_en[i] = 1'b0; src_len[i] = 0; hold_at[i] = -1; hold_len[i] = 0;
    end
    test_reset();
    test_single_input();
    test_round_robin();
    test_backpressure();
    test_grant_hold();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
